// File: rtl/pmp_seq_pkg.sv
// Shared types and constants for the PMP programming sequencer.
// Purely declarative; no timing or backpressure of its own.
package pmp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    DIS,
    ADDR,
    CFG,
    WAIT,
    CMP,
    RESP
  } state_e;

  localparam logic [7:0]  CSR_OP_WRITE = 8'd31;
  localparam logic [7:0]  CSR_OP_NONE  = 8'd0;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  localparam logic [1:0]  ERR_OK     = 2'd0;
  localparam logic [1:0]  ERR_RANGE  = 2'd1;
  localparam logic [1:0]  ERR_LOCKED = 2'd2;
  localparam logic [1:0]  ERR_VERIFY = 2'd3;

endpackage

// File: rtl/pmp_cfg_merge.sv
// Replaces one byte lane of a packed pmpcfg word; other lanes pass through.
// Combinational, zero latency, no handshake.
module pmp_cfg_merge (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = word_i;
    word_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/pmp_prog_sequencer.sv
// Programs one PMP entry per request (disable, address, config); response 5 cycles after accept, 7 with PMP_SEQ_VERIFY_EN.
// One request in flight: req_ready_o stays low until the response is consumed.
module pmp_prog_sequencer
  import pmp_seq_pkg::*;
#(
  parameter int unsigned NR_PMP_ENTRIES = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [3:0]   req_idx_i,
  input  logic [31:0]  req_addr_i,
  input  logic [7:0]   req_cfg_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [1:0]   rsp_err_o,
  output logic [11:0]  csr_addr_o,
  output logic [31:0]  csr_wdata_o,
  output logic [7:0]   csr_op_o,
  input  logic [127:0] pmpcfg_i,
  input  logic [511:0] pmpaddr_i
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [7:0]  csr_op_q, csr_op_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic [3:0]  idx_q;
  logic [31:0] addr_q;
  logic [7:0]  cfg_q;

  logic        req_hs;
  logic        idx_out_of_range;
  logic        entry_locked;
  logic [31:0] cfg_word;
  logic [7:0]  merge_byte;
  logic [31:0] merged_word;

  assign req_hs           = req_valid_i && req_ready_q;
  assign idx_out_of_range = 32'(idx_q) >= NR_PMP_ENTRIES;
  assign entry_locked     = pmpcfg_i[{idx_q, 3'b111}];
  assign cfg_word         = pmpcfg_i[{idx_q[3:2], 5'b00000} +: 32];
  // The disable write forces the lane to A=OFF; the final write installs the requested byte.
  assign merge_byte       = (state_q == ADDR) ? cfg_q : 8'h00;

  pmp_cfg_merge u_cfg_merge (
    .word_i (cfg_word),
    .lane_i (idx_q[1:0]),
    .byte_i (merge_byte),
    .word_o (merged_word)
  );

`ifdef PMP_SEQ_VERIFY_EN
  logic verify_ok;
  assign verify_ok = (pmpcfg_i[{idx_q, 3'b000} +: 8] == cfg_q) &&
                     (pmpaddr_i[{idx_q, 5'b00000} +: 32] == addr_q);
`else
  logic unused_pmpaddr;
  assign unused_pmpaddr = ^pmpaddr_i;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    csr_op_d    = CSR_OP_NONE;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_hs) state_d = CHK;
      end
      CHK: begin
        if (idx_out_of_range) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_RANGE;
        end else if (entry_locked) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_LOCKED;
        end else begin
          state_d     = DIS;
          csr_op_d    = CSR_OP_WRITE;
          csr_addr_d  = CSR_PMPCFG0 + {10'b0, idx_q[3:2]};
          csr_wdata_d = merged_word;
        end
      end
      DIS: begin
        state_d     = ADDR;
        csr_op_d    = CSR_OP_WRITE;
        csr_addr_d  = CSR_PMPADDR0 + {8'b0, idx_q};
        csr_wdata_d = addr_q;
      end
      ADDR: begin
        state_d     = CFG;
        csr_op_d    = CSR_OP_WRITE;
        csr_addr_d  = CSR_PMPCFG0 + {10'b0, idx_q[3:2]};
        csr_wdata_d = merged_word;
      end
`ifdef PMP_SEQ_VERIFY_EN
      CFG: state_d = WAIT;
      WAIT: state_d = CMP;
      CMP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = verify_ok ? ERR_OK : ERR_VERIFY;
      end
`else
      CFG: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ERR_OK;
      end
`endif
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      csr_op_q    <= CSR_OP_NONE;
      csr_addr_q  <= 12'h000;
      csr_wdata_q <= 32'h0;
      idx_q       <= 4'h0;
      addr_q      <= 32'h0;
      cfg_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      csr_op_q    <= csr_op_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      if (req_hs) begin
        idx_q  <= req_idx_i;
        addr_q <= req_addr_i;
        cfg_q  <= req_cfg_i;
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign csr_op_o    = csr_op_q;
  assign csr_addr_o  = csr_addr_q;
  assign csr_wdata_o = csr_wdata_q;

endmodule
